// File: rtl/pacote_saida.sv
// Shared types and constants for the output path: FSM states, seven-segment
// patterns and a sizing helper.
package pacote_saida;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    CONCLUI
  } estado_t;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  // Active-low patterns, bit order gfedcba
  localparam logic [6:0] SEG_DIGITO [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Bits needed to hold the value n
  function automatic int unsigned quantos_bits(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Single digit to active-low seven-segment pattern; non-decimal codes and the
// blank request both produce a dark display.
module decodificador_7seg
  import pacote_saida::*;
(
  input  logic [3:0] digito,
  input  logic       apaga,
  output logic [6:0] segmentos_c
);

  always_comb begin
    segmentos_c = SEG_APAGADO;
    if (!apaga && (digito <= 4'd9)) segmentos_c = SEG_DIGITO[digito];
  end

endmodule

// File: rtl/conversor_bcd_sequencial.sv
// Sequential double-dabble binary-to-BCD converter with double-buffered BCD
// and seven-segment outputs, one input bit per clock.
module conversor_bcd_sequencial
  import pacote_saida::*;
#(
  parameter int unsigned LARGURA       = 13,
  parameter int unsigned DIGITOS       = 4,
  parameter int unsigned SUPRIME_ZEROS = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Inicia,
  input  logic [LARGURA-1:0]     Valor,
  output logic                   Ocupado,
  output logic                   Pronto,
  output logic                   Descartado,
  output logic                   Excesso,
  output logic [4*DIGITOS-1:0]   Bcd,
  output logic [7*DIGITOS-1:0]   Segmentos
);

  localparam int unsigned W_BCD  = 4 * DIGITOS;
  localparam int unsigned W_SEG  = 7 * DIGITOS;
  localparam int unsigned W_CONT = quantos_bits(LARGURA);

  estado_t             estado;
  logic [LARGURA-1:0]  valor_sr;
  logic [W_BCD-1:0]    rascunho;
  logic [W_BCD-1:0]    ajustado;
  logic [W_BCD-1:0]    bcd_novo;
  logic [W_CONT-1:0]   cont;
  logic                estouro;
  logic                zeros_acima;
  logic [DIGITOS-1:0]  apaga;
  logic [W_SEG-1:0]    seg_novo;
  logic [W_SEG-1:0]    seg_reset;

  // Add-3 correction applied before each shift
  always_comb begin
    ajustado = rascunho;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (rascunho[4*i +: 4] >= 4'd5) ajustado[4*i +: 4] = rascunho[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_novo = estouro ? {DIGITOS{4'h9}} : rascunho;

  // Leading-zero blanking of the value about to be committed
  always_comb begin
    zeros_acima = 1'b1;
    apaga       = '0;
    for (int i = int'(DIGITOS) - 1; i >= 1; i--) begin
      zeros_acima = zeros_acima && (bcd_novo[4*i +: 4] == 4'd0);
      apaga[i]    = (SUPRIME_ZEROS != 0) && zeros_acima;
    end
  end

  for (genvar g = 0; g < int'(DIGITOS); g++) begin : g_display
    decodificador_7seg u_decodificador (
      .digito      (bcd_novo[4*g +: 4]),
      .apaga       (apaga[g]),
      .segmentos_c (seg_novo[7*g +: 7])
    );

    if ((g > 0) && (SUPRIME_ZEROS != 0)) begin : g_rst_apagado
      assign seg_reset[7*g +: 7] = SEG_APAGADO;
    end else begin : g_rst_zero
      assign seg_reset[7*g +: 7] = SEG_DIGITO[0];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado     <= OCIOSO;
      valor_sr   <= '0;
      rascunho   <= '0;
      cont       <= '0;
      estouro    <= 1'b0;
      Ocupado    <= 1'b0;
      Pronto     <= 1'b0;
      Descartado <= 1'b0;
      Excesso    <= 1'b0;
      Bcd        <= '0;
      Segmentos  <= seg_reset;
    end else begin
      Pronto     <= 1'b0;
      Descartado <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (Inicia) begin
            valor_sr <= Valor;
            rascunho <= '0;
            cont     <= W_CONT'(LARGURA);
            estouro  <= 1'b0;
            Ocupado  <= 1'b1;
            estado   <= CONVERTE;
          end
        end
        CONVERTE: begin
          Descartado            <= Inicia;
          {rascunho, valor_sr}  <= {ajustado[W_BCD-2:0], valor_sr, 1'b0};
          estouro               <= estouro | ajustado[W_BCD-1];
          cont                  <= cont - W_CONT'(1);
          if (cont == W_CONT'(1)) estado <= CONCLUI;
        end
        CONCLUI: begin
          Descartado <= Inicia;
          Bcd        <= bcd_novo;
          Excesso    <= estouro;
          Segmentos  <= seg_novo;
          Pronto     <= 1'b1;
          Ocupado    <= 1'b0;
          estado     <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Bench for conversor_bcd_sequencial: three instances (defaults, no zero
// suppression, 14-bit input) checked against a decimal/segment model.
module tb_conversor_bcd_sequencial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ini_a, ini_b, ini_c;
  logic [12:0] val_a, val_b;
  logic [13:0] val_c;

  logic        ocu_a, pro_a, des_a, exc_a;
  logic        ocu_b, pro_b, des_b, exc_b;
  logic        ocu_c, pro_c, des_c, exc_c;
  logic [15:0] bcd_a, bcd_b, bcd_c;
  logic [27:0] seg_a, seg_b, seg_c;

  conversor_bcd_sequencial dut_a (
    .Clock(clk), .Reset(rst), .Inicia(ini_a), .Valor(val_a),
    .Ocupado(ocu_a), .Pronto(pro_a), .Descartado(des_a), .Excesso(exc_a),
    .Bcd(bcd_a), .Segmentos(seg_a)
  );

  conversor_bcd_sequencial #(.SUPRIME_ZEROS(0)) dut_b (
    .Clock(clk), .Reset(rst), .Inicia(ini_b), .Valor(val_b),
    .Ocupado(ocu_b), .Pronto(pro_b), .Descartado(des_b), .Excesso(exc_b),
    .Bcd(bcd_b), .Segmentos(seg_b)
  );

  conversor_bcd_sequencial #(.LARGURA(14)) dut_c (
    .Clock(clk), .Reset(rst), .Inicia(ini_c), .Valor(val_c),
    .Ocupado(ocu_c), .Pronto(pro_c), .Descartado(des_c), .Excesso(exc_c),
    .Bcd(bcd_c), .Segmentos(seg_c)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        exc;
    logic [27:0] seg;
  } esperado_t;

  esperado_t   sb_a[$], sb_b[$], sb_c[$];
  logic [15:0] ultimo [3];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pro_a = 0;
  int          n_des_a = 0;

  always @(negedge clk) begin
    if (pro_a) n_pro_a++;
    if (des_a) n_des_a++;
  end

  function automatic logic [6:0] digito_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7f;
    endcase
  endfunction

  function automatic logic [15:0] para_bcd(input int v);
    logic [15:0] r;
    int x;
    x = (v > 9999) ? 9999 : v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] seg_model(input logic [15:0] b, input bit sup);
    logic [27:0] s;
    logic        lead;
    logic [3:0]  d;
    lead = 1'b1;
    s    = '0;
    for (int i = 3; i >= 0; i--) begin
      d    = b[4*i +: 4];
      lead = lead && (d == 4'd0);
      s[7*i +: 7] = (sup && (i > 0) && lead) ? 7'h7f : digito_seg(d);
    end
    return s;
  endfunction

  task automatic le(input int sel, output logic [15:0] ob, output logic oe,
                    output logic [27:0] os, output logic oo, output logic op);
    case (sel)
      0:       begin ob = bcd_a; oe = exc_a; os = seg_a; oo = ocu_a; op = pro_a; end
      1:       begin ob = bcd_b; oe = exc_b; os = seg_b; oo = ocu_b; op = pro_b; end
      default: begin ob = bcd_c; oe = exc_c; os = seg_c; oo = ocu_c; op = pro_c; end
    endcase
  endtask

  // Drives a one-cycle start and records the expected result; returns at the
  // falling edge right after the accepting edge
  task automatic dispara(input int sel, input int v);
    esperado_t e;
    e.bcd = para_bcd(v);
    e.exc = (v > 9999);
    e.seg = seg_model(e.bcd, sel != 1);
    @(negedge clk);
    case (sel)
      0:       begin val_a = 13'(v); ini_a = 1'b1; sb_a.push_back(e); end
      1:       begin val_b = 13'(v); ini_b = 1'b1; sb_b.push_back(e); end
      default: begin val_c = 14'(v); ini_c = 1'b1; sb_c.push_back(e); end
    endcase
    @(negedge clk);
    ini_a = 1'b0; ini_b = 1'b0; ini_c = 1'b0;
  endtask

  // Waits (bounded) for Pronto; lat counts edges since the accepting edge
  task automatic espera(input int sel, input int inicio, output int lat, output int ocup);
    logic [15:0] ob; logic oe; logic [27:0] os; logic oo; logic op;
    lat  = inicio;
    ocup = 0;
    forever begin
      le(sel, ob, oe, os, oo, op);
      if (op) return;
      if (oo) ocup++;
      if (lat >= 60) begin lat = -1; return; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ini_a = 1'b0; ini_b = 1'b0; ini_c = 1'b0;
    val_a = '0; val_b = '0; val_c = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ultimo[0] = '0; ultimo[1] = '0; ultimo[2] = '0;
    n_cmp++;
    if ({ocu_a, pro_a, des_a, exc_a} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags_a: got %b expected 0000", {ocu_a, pro_a, des_a, exc_a});
    end
    n_cmp++;
    if (bcd_a !== 16'h0000) begin n_err++; $display("FAIL reset_bcd_a: got %h expected 0000", bcd_a); end
    n_cmp++;
    if (seg_a !== seg_model(16'h0, 1'b1)) begin
      n_err++; $display("FAIL reset_seg_a: got %h expected %h", seg_a, seg_model(16'h0, 1'b1));
    end
    n_cmp++;
    if (seg_b !== seg_model(16'h0, 1'b0)) begin
      n_err++; $display("FAIL reset_seg_b: got %h expected %h", seg_b, seg_model(16'h0, 1'b0));
    end
    n_cmp++;
    if ({ocu_b, pro_b, des_b, exc_b, ocu_c, pro_c, des_c, exc_c} !== 8'h00 ||
        bcd_b !== 16'h0 || bcd_c !== 16'h0 || seg_c !== seg_model(16'h0, 1'b1)) begin
      n_err++; $display("FAIL reset_bc: got %h/%h/%h expected 0/0/%h", bcd_b, bcd_c, seg_c,
                        seg_model(16'h0, 1'b1));
    end
  endtask

  task automatic test_conversao(input int sel, input int v, input string rotulo);
    int lat, ocup, larg;
    esperado_t e;
    bit vazio;
    logic [15:0] ob; logic oe; logic [27:0] os; logic oo; logic op;
    larg = (sel == 2) ? 14 : 13;
    dispara(sel, v);
    le(sel, ob, oe, os, oo, op);
    n_cmp++;
    if (ob !== ultimo[sel]) begin
      n_err++; $display("FAIL %s hold: got %h expected %h", rotulo, ob, ultimo[sel]);
    end
    espera(sel, 0, lat, ocup);
    n_cmp++;
    if (lat !== larg + 1) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", rotulo, lat, larg + 1); end
    n_cmp++;
    if (ocup !== larg + 1) begin n_err++; $display("FAIL %s busy: got %0d expected %0d", rotulo, ocup, larg + 1); end
    le(sel, ob, oe, os, oo, op);
    n_cmp++;
    if (oo !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done: got %b expected 0", rotulo, oo); end
    case (sel)
      0:       begin vazio = (sb_a.size() == 0); if (!vazio) e = sb_a.pop_front(); end
      1:       begin vazio = (sb_b.size() == 0); if (!vazio) e = sb_b.pop_front(); end
      default: begin vazio = (sb_c.size() == 0); if (!vazio) e = sb_c.pop_front(); end
    endcase
    n_cmp++;
    if (vazio) begin
      n_err++; $display("FAIL %s scoreboard: got empty expected entry", rotulo);
    end else begin
      if (ob !== e.bcd) begin n_err++; $display("FAIL %s bcd: got %h expected %h", rotulo, ob, e.bcd); end
      n_cmp++;
      if (oe !== e.exc) begin n_err++; $display("FAIL %s excess: got %b expected %b", rotulo, oe, e.exc); end
      n_cmp++;
      if (os !== e.seg) begin n_err++; $display("FAIL %s seg: got %h expected %h", rotulo, os, e.seg); end
      ultimo[sel] = e.bcd;
    end
  endtask

  task automatic test_descartado();
    int lat, ocup, p0, d0;
    esperado_t e;
    p0 = n_pro_a; d0 = n_des_a;
    dispara(0, 1234);
    repeat (3) @(negedge clk);
    val_a = 13'd999; ini_a = 1'b1;
    @(negedge clk);
    ini_a = 1'b0;
    n_cmp++;
    if (des_a !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b expected 1", des_a); end
    @(negedge clk);
    n_cmp++;
    if (des_a !== 1'b0) begin n_err++; $display("FAIL drop_width: got %b expected 0", des_a); end
    espera(0, 5, lat, ocup);
    n_cmp++;
    if (lat !== 14) begin n_err++; $display("FAIL drop_latency: got %0d expected 14", lat); end
    e = sb_a.pop_front();
    n_cmp++;
    if (bcd_a !== e.bcd) begin n_err++; $display("FAIL drop_bcd: got %h expected %h", bcd_a, e.bcd); end
    ultimo[0] = e.bcd;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ((n_pro_a - p0) !== 1 || (n_des_a - d0) !== 1) begin
      n_err++; $display("FAIL drop_counts: got pronto=%0d descartado=%0d expected 1/1",
                        n_pro_a - p0, n_des_a - d0);
    end
  endtask

  task automatic test_reset_meio();
    int p0;
    dispara(0, 5000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p0 = n_pro_a;
    sb_a.delete();
    ultimo[0] = '0; ultimo[1] = '0; ultimo[2] = '0;
    n_cmp++;
    if (ocu_a !== 1'b0 || pro_a !== 1'b0) begin
      n_err++; $display("FAIL midreset_busy: got %b%b expected 00", ocu_a, pro_a);
    end
    n_cmp++;
    if (bcd_a !== 16'h0) begin n_err++; $display("FAIL midreset_bcd: got %h expected 0000", bcd_a); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (n_pro_a !== p0) begin n_err++; $display("FAIL midreset_pronto: got %0d expected %0d", n_pro_a, p0); end
    test_conversao(0, 77, "after_reset_77");
  endtask

  task automatic test_back_to_back();
    int lat, ocup;
    esperado_t e;
    e.bcd = para_bcd(321); e.exc = 1'b0; e.seg = seg_model(e.bcd, 1'b1);
    @(negedge clk);
    val_a = 13'd321; ini_a = 1'b1;
    sb_a.push_back(e);
    @(negedge clk);
    espera(0, 0, lat, ocup);
    n_cmp++;
    if (lat !== 14) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 14", lat); end
    n_cmp++;
    if (des_a !== 1'b1) begin n_err++; $display("FAIL b2b_drop_at_commit: got %b expected 1", des_a); end
    e = sb_a.pop_front();
    n_cmp++;
    if (bcd_a !== e.bcd) begin n_err++; $display("FAIL b2b_first_bcd: got %h expected %h", bcd_a, e.bcd); end
    e.bcd = para_bcd(555); e.seg = seg_model(e.bcd, 1'b1);
    val_a = 13'd555;
    sb_a.push_back(e);
    @(negedge clk);
    ini_a = 1'b0;
    espera(0, 0, lat, ocup);
    n_cmp++;
    if (lat !== 14 || ocup !== 14) begin
      n_err++; $display("FAIL b2b_second_timing: got %0d/%0d expected 14/14", lat, ocup);
    end
    e = sb_a.pop_front();
    n_cmp++;
    if (bcd_a !== e.bcd || seg_a !== e.seg) begin
      n_err++; $display("FAIL b2b_second_result: got %h/%h expected %h/%h", bcd_a, seg_a, e.bcd, e.seg);
    end
  endtask

  initial begin
    test_reset();
    test_conversao(0, 8191, "max_8191");
    test_conversao(0, 42, "val_42");
    test_conversao(0, 0, "val_0");
    test_conversao(1, 42, "nosup_42");
    test_conversao(1, 0, "nosup_0");
    test_descartado();
    test_reset_meio();
    test_conversao(2, 12000, "w14_12000");
    test_conversao(2, 10, "w14_10");
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
